// File: rtl/wb_sram_slave.sv
// wb_sram_slave
//   Wishbone B4 registered-feedback slave backed by an on-chip SRAM of
//   MEM_WORDS words. Handles classic cycles and incrementing bursts
//   (linear and 4/8/16-beat wrap) with byte enables. Requests outside the
//   address window are terminated with ERR.
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   ADR            byte address (low byte-offset bits ignored)
//   CTI, BTE       cycle type / burst type of the current transfer
//   DAT_W, SEL     write data and byte enables
//   CYC, STB, WE   bus cycle, strobe, write enable
//   DAT_R          read data, valid while ACK is high
//   ACK, ERR       transfer acknowledge / error termination
//
// FSM states
//   state    | meaning
//   IDLE     | no transfer in flight; decoding a new request
//   ACKING   | ACK presented for the beat at ctr_q
//   ERRING   | ERR presented for one cycle, then back to IDLE
//   WAIT     | burst paused by the master (STB low), counter already advanced
module wb_sram_slave #(
  parameter int unsigned              WB_ADDR_WIDTH = 32,
  parameter int unsigned              WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0,
  parameter int unsigned              MEM_WORDS     = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic                       WE,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  output logic                       ACK,
  output logic                       ERR
);

  localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(SEL_W);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  // One extra bit so the window limit cannot overflow at the top of the map.
  localparam logic [WB_ADDR_WIDTH:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [WB_ADDR_WIDTH:0] WIN_HI =
    WIN_LO + (WB_ADDR_WIDTH+1)'(MEM_WORDS * SEL_W);

  localparam logic [2:0] CTI_INCR = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACKING = 2'd1,
    S_ERRING = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e                     state_q;
  logic [IDX_W-1:0]           ctr_q;
  logic [1:0]                 bte_q;
  logic [WB_DATA_WIDTH-1:0]   dat_r_q;

  logic [WB_DATA_WIDTH-1:0]   mem [MEM_WORDS];

  logic                       in_range;
  logic [IDX_W-1:0]           req_idx;
  logic [IDX_W-1:0]           wrap_mask;
  logic [IDX_W-1:0]           ctr_adv;
  logic                       wr_commit;

  assign in_range = ({1'b0, ADR} >= WIN_LO) && ({1'b0, ADR} < WIN_HI);

  // The base is aligned to the window size, so subtracting it leaves the
  // word-index bits of ADR untouched.
  assign req_idx = ADR[OFF_W +: IDX_W];

  always_comb begin
    wrap_mask = '1;
    unique case (bte_q)
      2'b01:   wrap_mask = IDX_W'(3);
      2'b10:   wrap_mask = IDX_W'(7);
      2'b11:   wrap_mask = IDX_W'(15);
      default: wrap_mask = '1;
    endcase
  end

  // Bits inside the mask count and wrap; bits outside it are held.
  assign ctr_adv = (ctr_q & ~wrap_mask) | ((ctr_q + IDX_W'(1)) & wrap_mask);

  assign wr_commit = (state_q == S_ACKING) && CYC && STB && WE;

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (SEL[b]) mem[ctr_q][8*b +: 8] <= DAT_W[8*b +: 8];
      end
    end
  end

  // Read data is fetched one edge ahead: for the first beat from the decoded
  // index, for follow-on beats from the advanced counter, so each ACK cycle
  // already has its word in dat_r_q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      bte_q   <= 2'b00;
      dat_r_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (CYC && STB) begin
            if (in_range) begin
              state_q <= S_ACKING;
              ctr_q   <= req_idx;
              bte_q   <= BTE;
              dat_r_q <= mem[req_idx];
            end else begin
              state_q <= S_ERRING;
            end
          end
        end
        S_ACKING: begin
          if (!CYC) begin
            state_q <= S_IDLE;
          end else if (STB) begin
            if (CTI == CTI_INCR) begin
              ctr_q   <= ctr_adv;
              dat_r_q <= mem[ctr_adv];
            end else begin
              state_q <= S_IDLE;
            end
          end else if (CTI == CTI_INCR) begin
            state_q <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ERRING: begin
          state_q <= S_IDLE;
        end
        S_WAIT: begin
          if (!CYC) begin
            state_q <= S_IDLE;
          end else if (STB) begin
            state_q <= S_ACKING;
            dat_r_q <= mem[ctr_q];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Terminations come from the registered state, qualified by the live bus
  // handshake: a master that drops STB or CYC during a predicted beat sees
  // no acknowledge for it, and nothing is ever acknowledged with CYC low.
  assign ACK   = (state_q == S_ACKING) && CYC && STB;
  assign ERR   = (state_q == S_ERRING) && CYC;
  assign DAT_R = dat_r_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
module tb_wb_sram_slave;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 64;

  logic        clk;
  logic        rstn;
  logic [31:0] ADR;
  logic [2:0]  CTI;
  logic [1:0]  BTE;
  logic [31:0] DAT_W;
  logic [3:0]  SEL;
  logic        CYC;
  logic        STB;
  logic        WE;
  logic [31:0] DAT_R;
  logic        ACK;
  logic        ERR;

  int n_cmp = 0;
  int n_err = 0;

  wb_sram_slave #(
    .WB_ADDR_WIDTH(32),
    .WB_DATA_WIDTH(32),
    .ADDR_BASE    (BASE),
    .MEM_WORDS    (WORDS)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .ADR  (ADR),
    .CTI  (CTI),
    .BTE  (BTE),
    .DAT_W(DAT_W),
    .SEL  (SEL),
    .CYC  (CYC),
    .STB  (STB),
    .WE   (WE),
    .DAT_R(DAT_R),
    .ACK  (ACK),
    .ERR  (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive point just after the rising edge; sample point on the falling edge.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp, input string tag);
    go();
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; DAT_W = dat; SEL = sel;
    CTI = 3'b000; BTE = 2'b00;
    mid(); check({tag, "_wait_ack"}, 32'(ACK), 32'd0);
    go();
    mid(); check({tag, "_ack"}, 32'(ACK), 32'd1);
    if (!we) check({tag, "_data"}, DAT_R, exp);
    go();
    STB = 1'b0;
    mid(); check({tag, "_ack_after"}, 32'(ACK), 32'd0);
    go();
    CYC = 1'b0; WE = 1'b0;
  endtask

  task automatic err_access(input logic [31:0] adr, input string tag);
    go();
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = adr; DAT_W = 32'hBAD0_BAD0;
    SEL = 4'hF; CTI = 3'b000;
    mid(); check({tag, "_err_wait"}, 32'(ERR), 32'd0);
    go();
    mid(); check({tag, "_err"}, 32'(ERR), 32'd1);
    check({tag, "_ack"}, 32'(ACK), 32'd0);
    go();
    STB = 1'b0;
    mid(); check({tag, "_err_once"}, 32'(ERR), 32'd0);
    go();
    CYC = 1'b0; WE = 1'b0;
  endtask

  // Data convention: word w of a region holds dbase + w.
  task automatic burst(input logic we, input int first, input logic [1:0] bte, input int n,
                       input int gap_after, input int gap_len, input int abort_at,
                       input logic [31:0] dbase, input string tag);
    int mask;
    int w;
    mask = (bte == 2'b00) ? (WORDS - 1) : (bte == 2'b01) ? 3 : (bte == 2'b10) ? 7 : 15;
    go();
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = BASE + 32'(first * 4); BTE = bte;
    CTI = (n == 1) ? 3'b111 : 3'b010; SEL = 4'hF; DAT_W = 32'h0;
    mid(); check({tag, "_wait_ack"}, 32'(ACK), 32'd0);
    for (int k = 0; k < n; k++) begin
      go();
      if (k == abort_at) begin
        CYC = 1'b0; STB = 1'b0; DAT_W = 32'hDEAD_0000;
        mid(); check({tag, "_abort_now"}, 32'(ACK), 32'd0);
        go();
        WE = 1'b0;
        mid(); check({tag, "_abort_next"}, 32'(ACK), 32'd0);
        return;
      end
      w = (first & ~mask) | ((first + k) & mask);
      ADR = BASE + 32'(w * 4);
      CTI = (k == n - 1) ? 3'b111 : 3'b010;
      DAT_W = dbase + 32'(w);
      mid(); check($sformatf("%s_ack%0d", tag, k), 32'(ACK), 32'd1);
      if (!we) check($sformatf("%s_data%0d", tag, k), DAT_R, dbase + 32'(w));
      if (k == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          go();
          STB = 1'b0;
          mid(); check($sformatf("%s_gap%0d", tag, g), 32'(ACK), 32'd0);
        end
        go();
        STB = 1'b1;
        mid(); check({tag, "_resume_wait"}, 32'(ACK), 32'd0);
      end
    end
    // Hold the strobe one more cycle: the slave must be idle after end-of-burst.
    go();
    CTI = 3'b000;
    mid(); check({tag, "_ack_end"}, 32'(ACK), 32'd0);
    go();
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    mid(); check({tag, "_ack_cyc_low"}, 32'(ACK), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; ADR = '0; CTI = '0; BTE = '0; DAT_W = '0; SEL = '0;
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    repeat (3) @(posedge clk);
    mid();
    check("rst_ack", 32'(ACK), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_dat", DAT_R, 32'd0);
    go();
    rstn = 1'b1;

    classic(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, "cw");
    classic(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, "cr");

    classic(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, 32'h0, "be_full");
    classic(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, "be_part");
    classic(1'b0, BASE + 32'h20, 32'h0, 4'hF, 32'h11BB_33DD, "be_rd");
    classic(1'b0, BASE + 32'h23, 32'h0, 4'hF, 32'h11BB_33DD, "be_rd_off");

    burst(1'b1, 0,  2'b00, 8, -1, 0, -1, 32'hA000_0000, "fillA");
    burst(1'b1, 16, 2'b00, 8, -1, 0, -1, 32'hB000_0000, "fillB");

    burst(1'b0, 5,  2'b10, 8, -1, 0, -1, 32'hA000_0000, "wrap8");
    burst(1'b0, 6,  2'b01, 4, -1, 0, -1, 32'hA000_0000, "wrap4");
    burst(1'b0, 16, 2'b00, 6,  2, 2, -1, 32'hB000_0000, "gap");

    err_access(BASE + 32'(WORDS * 4), "err_hi");
    err_access(BASE - 32'd4, "err_lo");
    classic(1'b0, BASE, 32'h0, 4'hF, 32'hA000_0000, "err_readback");

    burst(1'b1, 16, 2'b00, 4, -1, 0, 2, 32'hB000_0000, "abort");
    classic(1'b0, BASE + 32'(18 * 4), 32'h0, 4'hF, 32'hB000_0012, "abort_rd");

    go();
    CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = BASE + 32'h8; CTI = 3'b010; BTE = 2'b00;
    mid(); check("rstb_wait", 32'(ACK), 32'd0);
    go();
    mid(); check("rstb_ack0", 32'(ACK), 32'd1);
    check("rstb_data0", DAT_R, 32'hA000_0002);
    go();
    mid(); check("rstb_ack1", 32'(ACK), 32'd1);
    check("rstb_data1", DAT_R, 32'hA000_0003);
    #1;
    rstn = 1'b0;
    #1;
    check("rstb_async_ack", 32'(ACK), 32'd0);
    check("rstb_async_err", 32'(ERR), 32'd0);
    check("rstb_async_dat", DAT_R, 32'd0);
    go();
    CYC = 1'b0; STB = 1'b0;
    go();
    rstn = 1'b1;
    classic(1'b0, BASE + 32'h14, 32'h0, 4'hF, 32'hA000_0005, "post_rst_rd");

    burst(1'b1, 62, 2'b00, 4, -1, 0, -1, 32'hC000_0000, "linwrap_w");
    burst(1'b0, 62, 2'b00, 4, -1, 0, -1, 32'hC000_0000, "linwrap_r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
